// File: rtl/syn_pkg.sv
// -----------------------------------------------------------------------------
// syn_pkg
// Shared definitions for the synaptic current generator:
//   - default parameter constants (input count, weight width, current width,
//     decay shift)
//   - weight element / weight-vector typedefs for the default configuration
//   - reset value of every weight
//   - saturation ceiling of the output current (CUR_MAX) and a helper that
//     derives the ceiling for any current width
// No ports (package).
// -----------------------------------------------------------------------------
package syn_pkg;

    localparam int N_IN_DEF        = 4;
    localparam int W_W_DEF         = 3;
    localparam int CUR_W_DEF       = 5;
    localparam int DECAY_SHIFT_DEF = 1;

    // Every weight comes out of reset as 1 so each input starts out live.
    localparam int WEIGHT_RST = 1;

    function automatic int unsigned cur_max_of(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    localparam int unsigned CUR_MAX = cur_max_of(CUR_W_DEF);

    typedef logic [W_W_DEF-1:0] weight_t;
    typedef weight_t [N_IN_DEF-1:0] weight_vec_t;

endpackage

// File: rtl/syn_weight_regs.sv
// -----------------------------------------------------------------------------
// syn_weight_regs
// Per-input synaptic weight register file with a single-cycle write port.
// A write whose address is inside the file updates that weight on the same
// edge and raises wr_ack for exactly the following cycle; an out-of-range
// address is dropped without an ack. All weights are exposed in parallel.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset (weights -> 1, ack -> 0)
//   wr_en    in   write request, one cycle per write
//   wr_addr  in   weight index
//   wr_data  in   new weight value
//   wr_ack   out  one-cycle pulse after an accepted write
//   weights  out  all weights, weight i at [i*W_W +: W_W]
// -----------------------------------------------------------------------------
module syn_weight_regs
    import syn_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    parameter int W_W  = W_W_DEF,
    localparam int AW  = $clog2(N_IN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [W_W-1:0]    wr_data,
    output logic              wr_ack,
    output logic [N_IN*W_W-1:0] weights
);

    logic           wr_ack_d, wr_ack_q;
    logic           addr_ok;
    logic [W_W-1:0] weights_d [N_IN];
    logic [W_W-1:0] weights_q [N_IN];

    // The range check only matters when N_IN is not a power of two; the
    // address is widened so the comparison is done in full precision.
    always_comb begin
        addr_ok  = (32'(wr_addr) < 32'(N_IN));
        wr_ack_d = wr_en && addr_ok;
        for (int i = 0; i < N_IN; i++) begin
            weights_d[i] = weights_q[i];
            if (wr_ack_d && (32'(wr_addr) == 32'(i))) begin
                weights_d[i] = wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ack_q <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                weights_q[i] <= W_W'(WEIGHT_RST);
            end
        end else begin
            wr_ack_q <= wr_ack_d;
            for (int i = 0; i < N_IN; i++) begin
                weights_q[i] <= weights_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            weights[i*W_W +: W_W] = weights_q[i];
        end
    end

    assign wr_ack = wr_ack_q;

endmodule

// File: rtl/syn_current_gen.sv
// -----------------------------------------------------------------------------
// syn_current_gen
// Synaptic front-end for the LIF neuron. Each enabled cycle the registered
// current decays by a right shift and the weights of all spiking inputs are
// added; results above the output range clip to the maximum and flag sat for
// one cycle. Weights live in syn_weight_regs and are loaded via wr_en/wr_ack.
//
// Optional feature, macro SYN_INHIBIT_EN: input N_IN-1 becomes inhibitory
// (its weight is subtracted), the sum is evaluated signed with one extra bit
// and floored at 0; flooring never raises sat. Without the macro every input
// is excitatory and the datapath is purely unsigned.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   en        in   integration enable (0: current holds, spikes ignored)
//   spike_in  in   input spike lines
//   wr_en     in   weight write request
//   wr_addr   in   weight index
//   wr_data   in   weight value
//   wr_ack    out  one-cycle ack of an accepted write
//   current   out  registered synaptic current to the neuron
//   sat       out  high for the cycle after an update that clipped
// -----------------------------------------------------------------------------
module syn_current_gen
    import syn_pkg::*;
#(
    parameter int N_IN        = N_IN_DEF,
    parameter int W_W         = W_W_DEF,
    parameter int CUR_W       = CUR_W_DEF,
    parameter int DECAY_SHIFT = DECAY_SHIFT_DEF,
    localparam int AW         = $clog2(N_IN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [N_IN-1:0]  spike_in,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [W_W-1:0]   wr_data,
    output logic             wr_ack,
    output logic [CUR_W-1:0] current,
    output logic             sat
);

    // Wide enough that the decayed current plus every weight cannot wrap.
    localparam int MAX_W = (CUR_W > W_W) ? CUR_W : W_W;
    localparam int SUM_W = MAX_W + $clog2(N_IN) + 1;
`ifdef SYN_INHIBIT_EN
    localparam int ACC_W = SUM_W + 1;
`else
    localparam int ACC_W = SUM_W;
`endif
    localparam logic [CUR_W-1:0] CUR_MAX_L = CUR_W'(cur_max_of(CUR_W));

    logic [N_IN*W_W-1:0] weights;
    logic [CUR_W-1:0]    current_d, current_q;
    logic                sat_d, sat_q;
`ifdef SYN_INHIBIT_EN
    logic signed [ACC_W-1:0] acc;
`else
    logic [ACC_W-1:0]        acc;
`endif

    syn_weight_regs #(
        .N_IN (N_IN),
        .W_W  (W_W)
    ) u_weight_regs (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_ack  (wr_ack),
        .weights (weights)
    );

    // The accumulation reads the registered weights, so a write landing on
    // the same edge as a spike only takes effect from the following edge.
    always_comb begin
        current_d = current_q;
        sat_d     = 1'b0;
        acc       = '0;
        if (en) begin
            acc = ACC_W'(current_q >> DECAY_SHIFT);
            for (int i = 0; i < N_IN; i++) begin
                if (spike_in[i]) begin
`ifdef SYN_INHIBIT_EN
                    if (i == N_IN - 1) begin
                        acc = acc - ACC_W'(weights[i*W_W +: W_W]);
                    end else begin
                        acc = acc + ACC_W'(weights[i*W_W +: W_W]);
                    end
`else
                    acc = acc + ACC_W'(weights[i*W_W +: W_W]);
`endif
                end
            end
`ifdef SYN_INHIBIT_EN
            // Negative results floor at zero without flagging saturation.
            if (acc[ACC_W-1]) begin
                current_d = '0;
            end else if (acc > $signed(ACC_W'(CUR_MAX_L))) begin
                current_d = CUR_MAX_L;
                sat_d     = 1'b1;
            end else begin
                current_d = acc[CUR_W-1:0];
            end
`else
            if (acc > ACC_W'(CUR_MAX_L)) begin
                current_d = CUR_MAX_L;
                sat_d     = 1'b1;
            end else begin
                current_d = acc[CUR_W-1:0];
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            current_q <= '0;
            sat_q     <= 1'b0;
        end else begin
            current_q <= current_d;
            sat_q     <= sat_d;
        end
    end

    assign current = current_q;
    assign sat     = sat_q;

endmodule

// File: tb/tb_syn_current_gen.sv
// -----------------------------------------------------------------------------
// tb_syn_current_gen
// Directed self-checking bench for syn_current_gen. Each step drives inputs on
// the falling edge, queues the expected current/sat/wr_ack, and compares them
// just after the following rising edge. A second instance with N_IN=3 covers
// the out-of-range write address, which a 4-input build cannot express.
// -----------------------------------------------------------------------------
module tb_syn_current_gen;
    import syn_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] spike_in;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [2:0] wr_data;
    logic       wr_ack;
    logic [4:0] current;
    logic       sat;

    logic       en3;
    logic [2:0] spike3;
    logic       wr_en3;
    logic [1:0] wr_addr3;
    logic [2:0] wr_data3;
    logic       wr_ack3;
    logic [4:0] current3;
    logic       sat3;

    typedef struct {
        string      tag;
        logic [4:0] cur;
        logic       sat;
        logic       ack;
    } exp_t;

    exp_t sb_q[$];
    int   check_count = 0;
    int   pass_count  = 0;
    int   fail_count  = 0;

    always #5 clk = ~clk;

    syn_current_gen dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .spike_in (spike_in),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .current  (current),
        .sat      (sat)
    );

    syn_current_gen #(.N_IN(3)) dut3 (
        .clk      (clk),
        .reset    (reset),
        .en       (en3),
        .spike_in (spike3),
        .wr_en    (wr_en3),
        .wr_addr  (wr_addr3),
        .wr_data  (wr_data3),
        .wr_ack   (wr_ack3),
        .current  (current3),
        .sat      (sat3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_count++;
            fail_count++;
            $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb_q.pop_front();
            check({e.tag, ".current"}, 32'(current), 32'(e.cur));
            check({e.tag, ".sat"},     32'(sat),     32'(e.sat));
            check({e.tag, ".wr_ack"},  32'(wr_ack),  32'(e.ack));
        end
    endtask

    task automatic applyStimulus(input string tag, input logic en_v, input logic [3:0] spk,
                                 input logic wr_v, input logic [1:0] addr, input logic [2:0] data,
                                 input logic [4:0] exp_cur, input logic exp_sat, input logic exp_ack);
        exp_t e;
        @(negedge clk);
        en       = en_v;
        spike_in = spk;
        wr_en    = wr_v;
        wr_addr  = addr;
        wr_data  = data;
        e.tag = tag;
        e.cur = exp_cur;
        e.sat = exp_sat;
        e.ack = exp_ack;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        reset    = 1'b0;
        en       = 1'b0;
        spike_in = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        en3      = 1'b0;
        spike3   = '0;
        wr_en3   = 1'b0;
        wr_addr3 = '0;
        wr_data3 = '0;

        #12;
        check("reset.current", 32'(current), 32'd0);
        check("reset.sat",     32'(sat),     32'd0);
        check("reset.wr_ack",  32'(wr_ack),  32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Write, single-cycle ack, then one spike decaying away.
        applyStimulus("t1.wr0",    1'b0, 4'b0000, 1'b1, 2'd0, 3'd7, 5'd0, 1'b0, 1'b1);
        applyStimulus("t1.spike",  1'b1, 4'b0001, 1'b0, 2'd0, 3'd0, 5'd7, 1'b0, 1'b0);
        applyStimulus("t1.dec1",   1'b1, 4'b0000, 1'b0, 2'd0, 3'd0, 5'd3, 1'b0, 1'b0);
        applyStimulus("t1.dec2",   1'b1, 4'b0000, 1'b0, 2'd0, 3'd0, 5'd1, 1'b0, 1'b0);
        applyStimulus("t1.dec3",   1'b1, 4'b0000, 1'b0, 2'd0, 3'd0, 5'd0, 1'b0, 1'b0);

        // Back-to-back writes, then saturation and recovery.
        applyStimulus("t2.wr1",    1'b0, 4'b0000, 1'b1, 2'd1, 3'd7, 5'd0, 1'b0, 1'b1);
        applyStimulus("t2.wr2",    1'b0, 4'b0000, 1'b1, 2'd2, 3'd7, 5'd0, 1'b0, 1'b1);
        applyStimulus("t2.wr3",    1'b0, 4'b0000, 1'b1, 2'd3, 3'd7, 5'd0, 1'b0, 1'b1);
        applyStimulus("t2.all1",   1'b1, 4'b1111, 1'b0, 2'd0, 3'd0, 5'd28, 1'b0, 1'b0);
        applyStimulus("t2.clip",   1'b1, 4'b1111, 1'b0, 2'd0, 3'd0, 5'(CUR_MAX), 1'b1, 1'b0);
        applyStimulus("t2.off1",   1'b1, 4'b0000, 1'b0, 2'd0, 3'd0, 5'd15, 1'b0, 1'b0);
        applyStimulus("t2.off2",   1'b1, 4'b0000, 1'b0, 2'd0, 3'd0, 5'd7, 1'b0, 1'b0);

        // Build current 12, then hold with en=0 while spikes and a write arrive.
        applyStimulus("t3.dec1",   1'b1, 4'b0000, 1'b0, 2'd0, 3'd0, 5'd3, 1'b0, 1'b0);
        applyStimulus("t3.dec2",   1'b1, 4'b0000, 1'b0, 2'd0, 3'd0, 5'd1, 1'b0, 1'b0);
        applyStimulus("t3.dec3",   1'b1, 4'b0000, 1'b0, 2'd0, 3'd0, 5'd0, 1'b0, 1'b0);
        applyStimulus("t3.wr0",    1'b0, 4'b0000, 1'b1, 2'd0, 3'd5, 5'd0, 1'b0, 1'b1);
        applyStimulus("t3.to12",   1'b1, 4'b0011, 1'b0, 2'd0, 3'd0, 5'd12, 1'b0, 1'b0);
        applyStimulus("t3.hold1",  1'b0, 4'b1111, 1'b0, 2'd0, 3'd0, 5'd12, 1'b0, 1'b0);
        applyStimulus("t3.holdwr", 1'b0, 4'b1111, 1'b1, 2'd1, 3'd4, 5'd12, 1'b0, 1'b1);
        applyStimulus("t3.hold2",  1'b0, 4'b1111, 1'b0, 2'd0, 3'd0, 5'd12, 1'b0, 1'b0);

        // Same-edge write and spike on input 2 uses the old weight.
        applyStimulus("t4.wr2",    1'b0, 4'b0000, 1'b1, 2'd2, 3'd1, 5'd12, 1'b0, 1'b1);
        applyStimulus("t4.dec1",   1'b1, 4'b0000, 1'b0, 2'd0, 3'd0, 5'd6, 1'b0, 1'b0);
        applyStimulus("t4.dec2",   1'b1, 4'b0000, 1'b0, 2'd0, 3'd0, 5'd3, 1'b0, 1'b0);
        applyStimulus("t4.dec3",   1'b1, 4'b0000, 1'b0, 2'd0, 3'd0, 5'd1, 1'b0, 1'b0);
        applyStimulus("t4.dec4",   1'b1, 4'b0000, 1'b0, 2'd0, 3'd0, 5'd0, 1'b0, 1'b0);
        applyStimulus("t4.same",   1'b1, 4'b0100, 1'b1, 2'd2, 3'd6, 5'd1, 1'b0, 1'b1);
        applyStimulus("t4.newwt",  1'b1, 4'b0100, 1'b0, 2'd0, 3'd0, 5'd6, 1'b0, 1'b0);

        // Reach 20 with a write in flight, then reset asynchronously mid-cycle.
        applyStimulus("t5.to20",   1'b1, 4'b1110, 1'b1, 2'd0, 3'd2, 5'd20, 1'b0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("t5.async.current", 32'(current), 32'd0);
        check("t5.async.sat",     32'(sat),     32'd0);
        check("t5.async.wr_ack",  32'(wr_ack),  32'd0);
        @(negedge clk);
        en       = 1'b0;
        spike_in = '0;
        wr_en    = 1'b0;
        reset    = 1'b1;
        applyStimulus("t5.w3rst",  1'b1, 4'b1000, 1'b0, 2'd0, 3'd0, 5'd1, 1'b0, 1'b0);
        applyStimulus("t5.w0rst",  1'b1, 4'b0001, 1'b0, 2'd0, 3'd0, 5'd1, 1'b0, 1'b0);

        // Input 3 as inhibitory when the feature is built in.
        applyStimulus("t6.wr3",    1'b0, 4'b0000, 1'b1, 2'd3, 3'd5, 5'd1, 1'b0, 1'b1);
        applyStimulus("t6.wr0",    1'b0, 4'b0000, 1'b1, 2'd0, 3'd7, 5'd1, 1'b0, 1'b1);
        applyStimulus("t6.wr1",    1'b0, 4'b0000, 1'b1, 2'd1, 3'd5, 5'd1, 1'b0, 1'b1);
        applyStimulus("t6.dec",    1'b1, 4'b0000, 1'b0, 2'd0, 3'd0, 5'd0, 1'b0, 1'b0);
        applyStimulus("t6.to12",   1'b1, 4'b0011, 1'b0, 2'd0, 3'd0, 5'd12, 1'b0, 1'b0);
`ifdef SYN_INHIBIT_EN
        applyStimulus("t6.inh1",   1'b1, 4'b1000, 1'b0, 2'd0, 3'd0, 5'd1, 1'b0, 1'b0);
        applyStimulus("t6.floor",  1'b1, 4'b1000, 1'b0, 2'd0, 3'd0, 5'd0, 1'b0, 1'b0);
`else
        applyStimulus("t6.exc1",   1'b1, 4'b1000, 1'b0, 2'd0, 3'd0, 5'd11, 1'b0, 1'b0);
        applyStimulus("t6.exc2",   1'b1, 4'b1000, 1'b0, 2'd0, 3'd0, 5'd10, 1'b0, 1'b0);
`endif

        // Out-of-range address on the 3-input instance.
        @(negedge clk);
        en       = 1'b0;
        spike_in = '0;
        wr_en3   = 1'b1;
        wr_addr3 = 2'd3;
        wr_data3 = 3'd7;
        @(posedge clk);
        #1;
        check("oor.wr_ack", 32'(wr_ack3), 32'd0);
        @(negedge clk);
        wr_en3 = 1'b0;
        en3    = 1'b1;
        spike3 = 3'b111;
        @(posedge clk);
        #1;
        check("oor.current", 32'(current3), 32'd3);
        check("oor.sat",     32'(sat3),     32'd0);
        @(negedge clk);
        en3      = 1'b0;
        spike3   = '0;
        wr_en3   = 1'b1;
        wr_addr3 = 2'd2;
        wr_data3 = 3'd4;
        @(posedge clk);
        #1;
        check("inr.wr_ack", 32'(wr_ack3), 32'd1);
        @(negedge clk);
        wr_en3 = 1'b0;
        en3    = 1'b1;
        spike3 = 3'b100;
        @(posedge clk);
        #1;
        check("inr.current", 32'(current3), 32'd5);
        check("inr.wr_ack2", 32'(wr_ack3),  32'd0);
        @(negedge clk);
        en3    = 1'b0;
        spike3 = '0;

        if (sb_q.size() != 0) begin
            check_count++;
            fail_count++;
            $error("[TB] FAIL scoreboard.drain: observed %0d leftover expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
